// File: rtl/div_pkg.sv
// Shared definitions for the sequential 8/8 restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_ITER  = 8;
    localparam int CNT_W     = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SUB,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/seq_divider_8_sub_9.sv
// 9-bit subtractor shared between the divider and multiplier datapaths.
module sub_9 (
    input  logic [8:0] A,
    input  logic [8:0] B,
    output logic [8:0] Diff
);

    assign Diff = A - B;

endmodule

// File: rtl/seq_divider_8.sv
// Sequential unsigned 8/8 restoring divider (shift/subtract, 16 busy cycles).
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero
// straight to DONE with Div0 raised; otherwise a zero divisor runs the full
// sequence and Div0 stays 0.
module seq_divider_8
    import div_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 LoadDivisor,
    input  logic [DIV_WIDTH-1:0] Din,
    output logic [DIV_WIDTH-1:0] Quotient,
    output logic [DIV_WIDTH-1:0] Remainder,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Div0
);

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZERO_DETECT = 1'b1;
`else
    localparam bit ZERO_DETECT = 1'b0;
`endif

    div_state_t           state;
    logic [DIV_WIDTH:0]   a;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] divisor;
    logic [CNT_W-1:0]     count;
    logic                 busy_r;
    logic                 done_r;
    logic                 div0_r;
    logic [DIV_WIDTH:0]   diff;

    sub_9 u_sub (
        .A    (a),
        .B    ({1'b0, divisor}),
        .Diff (diff)
    );

    // FSM and datapath registers; Busy/Done/Div0 are registered alongside state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            a       <= '0;
            q       <= '0;
            divisor <= '0;
            count   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Divisor capture uses the pre-edge divisor for the zero test.
                    if (LoadDivisor)
                        divisor <= Din;
                    if (Run) begin
                        if (ZERO_DETECT && (divisor == '0)) begin
                            q      <= '1;
                            a      <= {1'b0, Din};
                            div0_r <= 1'b1;
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            q      <= Din;
                            a      <= '0;
                            count  <= '0;
                            busy_r <= 1'b1;
                            state  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    {a, q} <= {a[DIV_WIDTH-1:0], q, 1'b0};
                    state  <= S_SUB;
                end
                S_SUB: begin
                    // diff[8] set means the trial subtraction went negative: restore.
                    if (!diff[DIV_WIDTH])
                        a <= diff;
                    q[0] <= ~diff[DIV_WIDTH];
                    if (count == CNT_W'(DIV_ITER - 1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    if (LoadDivisor)
                        divisor <= Din;
                    if (!Run) begin
                        done_r <= 1'b0;
                        div0_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Quotient  = q;
    assign Remainder = a[DIV_WIDTH-1:0];
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Div0      = div0_r;

endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: table of directed divisions plus
// hand-written sequences for held Run, mid-operation Reset and LoadDivisor timing.
module tb_seq_divider_8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       LoadDivisor;
    logic [7:0] Din;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       Div0;

    int errors = 0;
    int checks = 0;

    seq_divider_8 dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .LoadDivisor (LoadDivisor),
        .Din         (Din),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .Div0        (Div0)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] divisor;
        logic [7:0] dividend;
        logic [7:0] q;
        logic [7:0] r;
        int         cycles;
        int         busy_cycles;
        logic       div0;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_div(input logic [7:0] d);
        @(negedge Clk);
        LoadDivisor = 1'b1;
        Din         = d;
        @(negedge Clk);
        LoadDivisor = 1'b0;
    endtask

    // Counts rising edges until Done is seen (sampled at negedge); -1 on timeout.
    task automatic wait_done(output int cyc, output int bcyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        bcyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (Done)
                seen = 1'b1;
            else if (Busy)
                bcyc++;
        end
        if (!seen)
            cyc = -1;
    endtask

    task automatic start_run(input logic [7:0] dvd);
        @(negedge Clk);
        Run = 1'b1;
        Din = dvd;
    endtask

    task automatic end_run(input string tag, input logic [7:0] q, input logic [7:0] r);
        Run = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, "_done_clr"}, 32'(Done), 32'd0);
        chk({tag, "_div0_clr"}, 32'(Div0), 32'd0);
        chk({tag, "_q_keep"}, 32'(Quotient), 32'(q));
        chk({tag, "_r_keep"}, 32'(Remainder), 32'(r));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bcyc;
        int zc;
        int zb;
        logic zd;

`ifdef DIV_ZERO_DETECT_EN
        zc = 1;  zb = 0;  zd = 1'b1;
`else
        zc = 17; zb = 16; zd = 1'b0;
`endif
        vecs[0] = '{8'h07, 8'hC8, 8'h1C, 8'h04, 17, 16, 1'b0};
        vecs[1] = '{8'h01, 8'hFF, 8'hFF, 8'h00, 17, 16, 1'b0};
        vecs[2] = '{8'h09, 8'h05, 8'h00, 8'h05, 17, 16, 1'b0};
        vecs[3] = '{8'h00, 8'h2A, 8'hFF, 8'h2A, zc, zb, zd};
        vecs[4] = '{8'h0A, 8'h64, 8'h0A, 8'h00, 17, 16, 1'b0};
        vecs[5] = '{8'hFF, 8'hFE, 8'h00, 8'hFE, 17, 16, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 17, 16, 1'b0};
        vecs[7] = '{8'h03, 8'h00, 8'h00, 8'h00, 17, 16, 1'b0};
        vecs[8] = '{8'h10, 8'hFF, 8'h0F, 8'h0F, 17, 16, 1'b0};

        Reset = 1'b1; Run = 1'b0; LoadDivisor = 1'b0; Din = 8'h5A;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_q", 32'(Quotient), 32'd0);
        chk("rst_r", 32'(Remainder), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_div0", 32'(Div0), 32'd0);
        Reset = 1'b0;

        // Directed division table
        foreach (vecs[i]) begin
            load_div(vecs[i].divisor);
            start_run(vecs[i].dividend);
            wait_done(cyc, bcyc);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            chk($sformatf("v%0d_busy", i), 32'(bcyc), 32'(vecs[i].busy_cycles));
            chk($sformatf("v%0d_q", i), 32'(Quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i), 32'(Remainder), 32'(vecs[i].r));
            chk($sformatf("v%0d_div0", i), 32'(Div0), 32'(vecs[i].div0));
            end_run($sformatf("v%0d", i), vecs[i].q, vecs[i].r);
        end

        // Run held high long after completion: no re-trigger, results stable
        load_div(8'h07);
        start_run(8'hC8);
        wait_done(cyc, bcyc);
        chk("hold_cycles", 32'(cyc), 32'd17);
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            chk($sformatf("hold_%0d", k), {14'd0, Done, Busy, Quotient, Remainder},
                {14'd0, 1'b1, 1'b0, 8'h1C, 8'h04});
        end
        end_run("hold", 8'h1C, 8'h04);
        @(negedge Clk);
        chk("hold_idle_busy", 32'(Busy), 32'd0);

        // LoadDivisor pulsed while busy is ignored
        start_run(8'hC8);
        repeat (4) @(negedge Clk);
        LoadDivisor = 1'b1;
        Din         = 8'h03;
        repeat (2) @(negedge Clk);
        LoadDivisor = 1'b0;
        wait_done(cyc, bcyc);
        chk("ldbusy_done", 32'(cyc > 0), 32'd1);
        chk("ldbusy_q", 32'(Quotient), 32'h1C);
        chk("ldbusy_r", 32'(Remainder), 32'h04);
        end_run("ldbusy", 8'h1C, 8'h04);
        start_run(8'hC8);
        wait_done(cyc, bcyc);
        chk("ldbusy2_q", 32'(Quotient), 32'h1C);
        chk("ldbusy2_r", 32'(Remainder), 32'h04);
        end_run("ldbusy2", 8'h1C, 8'h04);

        // LoadDivisor and Run on the same IDLE edge: 05 / 05
        @(negedge Clk);
        Run = 1'b1; LoadDivisor = 1'b1; Din = 8'h05;
        @(posedge Clk);
        @(negedge Clk);
        LoadDivisor = 1'b0;
        Din         = 8'h00;
        wait_done(cyc, bcyc);
        chk("same_cycles", 32'(cyc + 1), 32'd17);
        chk("same_q", 32'(Quotient), 32'h01);
        chk("same_r", 32'(Remainder), 32'h00);
        end_run("same", 8'h01, 8'h00);

        // Reset asserted on cycle 6 of an operation
        load_div(8'h07);
        start_run(8'hC8);
        repeat (6) @(negedge Clk);
        chk("midrst_busy_pre", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("midrst_all", {21'd0, Div0, Done, Busy, Quotient, Remainder}, 32'd0);
        Reset = 1'b0;
        Run   = 1'b0;
        @(negedge Clk);
        chk("midrst_idle", {30'd0, Busy, Done}, 32'd0);

        // Divisor register was cleared by reset: next division sees divisor 0
        start_run(8'h2A);
        wait_done(cyc, bcyc);
        chk("postrst_cycles", 32'(cyc), 32'(zc));
        chk("postrst_q", 32'(Quotient), 32'hFF);
        chk("postrst_r", 32'(Remainder), 32'h2A);
        chk("postrst_div0", 32'(Div0), 32'(zd));
        end_run("postrst", 8'hFF, 8'h2A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider_8.md
SEQ_DIVIDER_8 -- requirements
Module: seq_divider_8

Interface
REQ-001 SHALL: Clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 SHALL: Run  input  1  level start request; held high by the user until Done is observed.
REQ-004 SHALL: LoadDivisor  input  1  capture Din into the divisor register.
REQ-005 SHALL: Din  input  8  unsigned operand (dividend on Run, divisor on LoadDivisor).
REQ-006 SHALL: Quotient  output  8  Q register contents.
REQ-007 SHALL: Remainder  output  8  A[7:0] register contents.
REQ-008 SHALL: Busy  output  1  high in SHIFT and SUB states.
REQ-009 SHALL: Done  output  1  high in DONE state.
REQ-010 SHALL: Div0  output  1  divide-by-zero flag (see Configuration); tied 0 when the feature is excluded.

Function
REQ-011 SHALL: operation is unsigned 8/8 restoring division (shift-subtract), the inverse of the shift-add multiplier datapath.
REQ-012 SHALL: registers: A 9-bit partial remainder, Q 8-bit, divisor 8-bit, iteration counter 3-bit, FSM state.
REQ-013 SHALL: FSM states IDLE, SHIFT, SUB, DONE.
REQ-014 SHALL: IDLE, Run=1 -> Q<=Din, A<=0, count<=0, next SHIFT; Run=0 -> stay.
REQ-015 SHALL: SHIFT -> {A,Q} shifted left one bit (Q[0]<=0), next SUB.
REQ-016 SHALL: SUB -> diff = A - {1'b0,divisor} (9-bit); diff[8]=0: A<=diff, Q[0]<=1; diff[8]=1: A unchanged, Q[0]<=0.
REQ-017 SHALL: SUB with count=7 -> next DONE; otherwise count<=count+1, next SHIFT.
REQ-018 SHALL: latency is exactly 16 cycles in SHIFT/SUB; Done rises on the 17th rising edge after the edge sampling Run in IDLE.
REQ-019 SHALL: DONE holds Quotient/Remainder stable; Run=0 -> IDLE, Run=1 -> stay (no re-trigger while Run held).
REQ-020 SHALL: Run changes while Busy are ignored.
REQ-021 SHALL: LoadDivisor honoured only in IDLE or DONE; ignored while Busy; outputs unaffected.
REQ-022 SHALL: LoadDivisor and Run both high in IDLE -> divisor captures Din and Q captures Din in the same edge.
REQ-023 SHALL: Quotient/Remainder retain last result in IDLE until the next Run.

Reset
REQ-024 SHALL: Reset has priority over every other input, in any state including mid-operation.
REQ-025 SHALL: reset values: state IDLE, A=0, Q=0, divisor=0, count=0, Quotient=0, Remainder=0, Busy=0, Done=0, Div0=0.

Configuration
REQ-026 SHALL: macro DIV_ZERO_DETECT_EN selects divide-by-zero handling.
REQ-027 SHALL: defined -> IDLE with Run=1 and divisor=0 goes directly to DONE next edge with Q=FF, A=Din, Div0=1; Div0 clears on leaving DONE or on Reset.
REQ-028 SHALL: undefined -> divisor=0 runs the full 16 cycles, naturally yielding Quotient=FF, Remainder=dividend; Div0 constant 0.

Structure
REQ-029 SHALL: shared package div_pkg holds state enum type, DIV_WIDTH=8, DIV_ITER=8.
REQ-030 SHALL: 9-bit subtractor is a separate sub-module sub_9 (A, B, Diff[8:0]), reusable by the multiplier lab datapath.
REQ-031 SHALL: FSM and datapath registers stay in seq_divider_8.

Verification
REQ-032 SHALL: divisor 07, Run with Din C8 (200) -> Done on cycle 17, Quotient 1C, Remainder 04.
REQ-033 SHALL: divisor 01, dividend FF -> Quotient FF, Remainder 00; divisor 09, dividend 05 -> Quotient 00, Remainder 05.
REQ-034 SHALL: divisor 00, dividend 2A -> with DIV_ZERO_DETECT_EN: Done after 1 cycle, Div0=1, Q=FF, R=2A; without: Done cycle 17, Div0=0, Q=FF, R=2A.
REQ-035 SHALL: Run held high 40 cycles after 200/7 -> single operation only, results stable, IDLE after Run drops.
REQ-036 SHALL: Reset asserted on cycle 6 of an operation -> next edge all outputs 0, state IDLE; LoadDivisor pulsed while Busy -> result unchanged.
